// File: rtl/jt6295_pkg.sv
// Shared constants for the MSM6295-style ADPCM decoder.
//   STEP_TABLE : 49-entry quantiser step sizes, indexed by the per-voice step index
//   ADJ        : step-index adjustment per nibble magnitude
//   IDX_MAX, ACC_W, ACC_MIN, ACC_MAX : range limits for index and accumulator
package jt6295_pkg;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned STEP_W = 11;
    localparam int unsigned ACC_W  = 12;

    localparam logic [IDX_W-1:0]        IDX_MAX = 6'd48;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -12'sd2048;
    localparam logic signed [ACC_W-1:0] ACC_MAX = 12'sd2047;

    localparam logic [STEP_W-1:0] STEP_TABLE [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Indexed by nibble magnitude (data[2:0]).
    localparam logic signed [4:0] ADJ [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

endpackage

// File: rtl/jt6295_step_rom.sv
// Step-size lookup with a registered output so it maps onto a block ROM.
//   clk, rst_n : clock and asynchronous active-low reset
//   cen        : load strobe; the lookup is captured only on cen edges
//   addr       : step index (0..48; larger values read the last entry)
//   step       : registered step size
module jt6295_step_rom
    import jt6295_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [IDX_W-1:0]  addr,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else if (cen) begin
            step_q <= (addr > IDX_MAX) ? STEP_TABLE[IDX_MAX] : STEP_TABLE[addr];
        end
    end

    assign step = step_q;

endmodule

// File: rtl/jt6295_adpcm.sv
// Four-voice time-multiplexed OKI ADPCM decoder.
//   clk, rst_n  : clock and asynchronous active-low reset
//   cen         : 4x sample-rate strobe; each strobe consumes one voice slot
//   en, start   : current slot is playing / current slot restarts
//   data        : ADPCM nibble (bit3 sign, bits2:0 magnitude)
//   slot        : slot consumed at the next cen
//   sound       : decoded sample of the last processed slot
//   sound_slot  : slot that sound belongs to
//   sound_vld   : one-clk pulse when sound/sound_slot update
// Pipeline: the cen edge captures the inputs and the step lookup; the next edge
// commits the decode to the slot state and the outputs.
module jt6295_adpcm
    import jt6295_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cen,
    input  logic                    en,
    input  logic                    start,
    input  logic [3:0]              data,
    output logic [1:0]              slot,
    output logic signed [ACC_W-1:0] sound,
    output logic [1:0]              sound_slot,
    output logic                    sound_vld
);

    localparam int unsigned SUM_W  = ACC_W + 2;
    localparam int unsigned IDXS_W = IDX_W + 1;
    localparam logic signed [SUM_W-1:0]  SUM_MAX = SUM_W'(ACC_MAX);
    localparam logic signed [SUM_W-1:0]  SUM_MIN = SUM_W'(ACC_MIN);
    localparam logic signed [IDXS_W-1:0] IDX_HI  = $signed({1'b0, IDX_MAX});

    // Per-slot decoder state
    logic [CHANNELS-1:0][ACC_W-1:0] acc_q;
    logic [CHANNELS-1:0][IDX_W-1:0] idx_q;

    logic [1:0] slot_q;

    // Stage-1 registers
    logic       s1_vld_q;
    logic [1:0] s1_slot_q;
    logic       s1_en_q;
    logic       s1_start_q;
    logic [3:0] s1_data_q;
    logic [STEP_W-1:0] step;

    // Output registers
    logic signed [ACC_W-1:0] sound_q;
    logic [1:0]              sound_slot_q;
    logic                    sound_vld_q;

    // Stage-2 combinational decode
    logic [12:0]              diff;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_new;
    logic signed [IDXS_W-1:0] idx_sum;
    logic [IDX_W-1:0]         idx_new;

    jt6295_step_rom u_step_rom (
        .clk  (clk),
        .rst_n(rst_n),
        .cen  (cen),
        .addr (idx_q[slot_q]),
        .step (step)
    );

    always_comb begin
        diff = 13'(step >> 3);
        if (s1_data_q[2]) diff = diff + 13'(step);
        if (s1_data_q[1]) diff = diff + 13'(step >> 1);
        if (s1_data_q[0]) diff = diff + 13'(step >> 2);

        if (s1_data_q[3]) begin
            sum = SUM_W'($signed(acc_q[s1_slot_q])) - $signed({1'b0, diff});
        end else begin
            sum = SUM_W'($signed(acc_q[s1_slot_q])) + $signed({1'b0, diff});
        end

        if (sum > SUM_MAX) begin
            acc_new = ACC_MAX;
        end else if (sum < SUM_MIN) begin
            acc_new = ACC_MIN;
        end else begin
            acc_new = sum[ACC_W-1:0];
        end

        idx_sum = $signed({1'b0, idx_q[s1_slot_q]}) + IDXS_W'(ADJ[s1_data_q[2:0]]);
        if (idx_sum[IDX_W]) begin
            idx_new = '0;
        end else if (idx_sum > IDX_HI) begin
            idx_new = IDX_MAX;
        end else begin
            idx_new = idx_sum[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            s1_vld_q     <= 1'b0;
            s1_slot_q    <= '0;
            s1_en_q      <= 1'b0;
            s1_start_q   <= 1'b0;
            s1_data_q    <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            sound_q      <= '0;
            sound_slot_q <= '0;
            sound_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= cen;
            if (cen) begin
                s1_slot_q  <= slot_q;
                s1_en_q    <= en;
                s1_start_q <= start;
                s1_data_q  <= data;
                slot_q     <= slot_q + 2'd1;
            end

            sound_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                sound_slot_q <= s1_slot_q;
                // Restart wins over play; an idle slot keeps its state but outputs silence.
                if (s1_start_q) begin
                    acc_q[s1_slot_q] <= '0;
                    idx_q[s1_slot_q] <= '0;
                    sound_q          <= '0;
                end else if (s1_en_q) begin
                    acc_q[s1_slot_q] <= acc_new;
                    idx_q[s1_slot_q] <= idx_new;
                    sound_q          <= acc_new;
                end else begin
                    sound_q <= '0;
                end
            end
        end
    end

    assign slot       = slot_q;
    assign sound      = sound_q;
    assign sound_slot = sound_slot_q;
    assign sound_vld  = sound_vld_q;

endmodule

// File: doc/jt6295_adpcm.md
JT6295_ADPCM -- requirements
Module: jt6295_adpcm

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of time-multiplexed voices; fixed at 4 in this core.
REQ-002 SHALL have port clk  input  1  system clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cen  input  1  4x sample-rate strobe, one clk wide; consecutive strobes at least 3 clk apart.
REQ-005 SHALL have port en  input  1  current slot's voice is playing.
REQ-006 SHALL have port start  input  1  current slot's voice restarts; clears its decoder state.
REQ-007 SHALL have port data  input  4  ADPCM nibble for the current slot; bit3 is the sign, bits2:0 the magnitude.
REQ-008 SHALL have port slot  output  2  index of the slot consumed at the next cen.
REQ-009 SHALL have port sound  output  12  signed decoded sample of the last processed slot.
REQ-010 SHALL have port sound_slot  output  2  slot that sound belongs to.
REQ-011 SHALL have port sound_vld  output  1  one-clk pulse when sound and sound_slot update.

Function
REQ-012 SHALL sample en, start and data only on clk edges where cen=1, attributing them to the current slot; after sampling, slot SHALL advance by 1 and wrap 3->0.
REQ-013 SHALL hold per slot a signed 12-bit accumulator acc and a 6-bit step index idx in the range 0..48.
REQ-014 Stage 1 (the clk edge with cen=1) SHALL register slot, en, start and data, and SHALL register step = STEP_TABLE[idx[slot]].
REQ-015 Stage 2 (next clk) SHALL compute diff = step>>3, plus step if data[2], plus step>>1 if data[1], plus step>>2 if data[0]; diff SHALL be 13-bit unsigned and each shift SHALL truncate.
REQ-016 Stage 2 SHALL form acc±diff with 14-bit width (subtract when data[3]=1), SHALL saturate the result to -2048..2047, and SHALL write it back to acc[slot].
REQ-017 Stage 2 SHALL update idx[slot] += ADJ[data[2:0]], where ADJ = {-1,-1,-1,-1,+2,+4,+6,+8}, and SHALL clamp the result to 0..48.
REQ-018 Stage 2 SHALL drive sound = the new acc, sound_slot = the registered slot, and sound_vld = 1; total latency SHALL be 2 clk from the cen edge.
REQ-019 When start=1: acc[slot] SHALL become 0, idx[slot] SHALL become 0, sound SHALL be 0, and no decode SHALL occur; start SHALL take priority over en.
REQ-020 When en=0 and start=0: acc and idx SHALL be held and sound SHALL be 0; sound_vld SHALL still pulse.
REQ-021 Slots SHALL be fully independent; a write to one slot SHALL never alter another slot's state.
REQ-022 If cen arrives while stage 2 is busy (a spacing violation), behaviour is undefined; the bench SHALL flag it via an assertion.

Reset
REQ-023 While rst_n=0, every acc and idx SHALL be 0, slot SHALL be 0, sound SHALL be 0, sound_slot SHALL be 0, sound_vld SHALL be 0, and all pipeline registers SHALL be cleared.
REQ-024 Reset asserted mid-pipeline SHALL discard the in-flight nibble; the first cen after release SHALL be processed as slot 0.

Structure
REQ-025 Package jt6295_pkg SHALL hold STEP_TABLE (49 x 11-bit entries, 16,17,19,21,23,25,28,31,34,37,41 ... 1552), the ADJ table, and the constants IDX_MAX=48, ACC_W=12, ACC_MIN=-2048 and ACC_MAX=2047.
REQ-026 Step lookup SHALL be one sub-module, jt6295_step_rom, with a registered output so it maps to block ROM; the rest of the logic SHALL stay flat.

Verification
REQ-027 Reset release, then a cen with en=1 and data=0x7 in slot 0 -> sound=30, sound_slot=0, idx[0]=8, sound_vld exactly 2 clk after cen.
REQ-028 Follow-on: the next slot-0 cen with data=0xF (idx 8, step 34) -> sound=-33 (30-63), idx[0]=16.
REQ-029 Repeated data=0x7 on slot 1 -> sound rises monotonically and saturates at 2047, and idx[1] clamps at 48; data=0x0 at idx 0 -> diff=2 and idx stays 0.
REQ-030 Interleaved nibbles 0x7,0x0,0xF,0x3 on slots 0..3 over 8 cens -> each slot matches a per-slot reference model, with no cross-talk.
REQ-031 start=1 together with en=1 on slot 2 -> sound=0, and acc[2]=0 and idx[2]=0; with en=0 on slot 3 -> sound=0 and state is retained for the next en=1.
REQ-032 rst_n pulled low 1 clk after a cen -> no sound_vld for that nibble, all outputs return to 0, and slot=0 after release.
